// File: rtl/gfx_rom_pkg.sv
// Shared types, default parameters and geometry helpers for the tile ROM fetcher.
// Latency: none (declarations only).
// Backpressure: not applicable.
package gfx_rom_pkg;

    localparam int AW_DEF      = 19;
    localparam int DW_DEF      = 32;
    localparam int PLANES_DEF  = 4;
    localparam int ROM_LAT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } fetch_state_e;

    // Pixels carried by one ROM word.
    function automatic int ppw_f(input int dw, input int planes);
        return dw / planes;
    endfunction

    // Width of the pixel index inside a word; never narrower than one bit.
    function automatic int idx_w_f(input int dw, input int planes);
        int ppw;
        ppw = dw / planes;
        return (ppw > 1) ? $clog2(ppw) : 1;
    endfunction

endpackage

// File: rtl/gfx_rom_if.sv
// Request, ROM and pixel signals of the tile fetcher bundled as one interface.
// Latency: none (wiring only).
// Backpressure: REQ_VALID/REQ_READY handshake; pixels are paced by PIX_EN.
interface gfx_rom_if
    import gfx_rom_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int PLANES = PLANES_DEF
);
    logic              REQ_VALID;
    logic              REQ_READY;
    logic [AW-1:0]     REQ_ADDR;
    logic              REQ_HFLIP;
    logic [7:0]        REQ_COL;
    logic [AW-2:0]     ROM_ADDR;
    logic              ROM_CEn;
    logic              ROM_OE_LO_n;
    logic              ROM_OE_HI_n;
    logic [DW-1:0]     ROM_DATA;
    logic              PIX_EN;
    logic              PIX_VALID;
    logic [PLANES-1:0] PIX_DATA;
    logic [7:0]        PIX_COL;
    logic              UNDERRUN;

    // Fetcher side.
    modport slave (
        input  REQ_VALID, REQ_ADDR, REQ_HFLIP, REQ_COL, ROM_DATA, PIX_EN,
        output REQ_READY, ROM_ADDR, ROM_CEn, ROM_OE_LO_n, ROM_OE_HI_n,
               PIX_VALID, PIX_DATA, PIX_COL, UNDERRUN
    );

    // Requester / ROM / video side.
    modport master (
        output REQ_VALID, REQ_ADDR, REQ_HFLIP, REQ_COL, ROM_DATA, PIX_EN,
        input  REQ_READY, ROM_ADDR, ROM_CEn, ROM_OE_LO_n, ROM_OE_HI_n,
               PIX_VALID, PIX_DATA, PIX_COL, UNDERRUN
    );
endinterface

// File: rtl/gfx_planar_shifter.sv
// Second word buffer of the double buffer: turns planar ROM words into pixels, optional hflip.
// Latency: one registered stage; a word waiting in the fetch buffer emits on the next PIX_EN.
// Backpressure: consumes the fetch buffer (drain_o) only on the PIX_EN that frees the shifter.
module gfx_planar_shifter
    import gfx_rom_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int PLANES = PLANES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              pix_en_i,
    input  logic              fb_full_i,
    input  logic [DW-1:0]     fb_dat_i,
    input  logic              fb_hflip_i,
    input  logic [7:0]        fb_col_i,
    output logic              drain_o,
    output logic              pix_vld_o,
    output logic [PLANES-1:0] pix_dat_o,
    output logic [7:0]        pix_col_o,
    output logic              underrun_o
);
    localparam int PPW = ppw_f(DW, PLANES);
    localparam int IW  = idx_w_f(DW, PLANES);
    localparam logic [IW-1:0] IDX_LAST = IW'(PPW - 1);

    logic [DW-1:0]     sh_dat_q, sh_dat_d;
    logic              sh_full_q, sh_full_d;
    logic              sh_hflip_q, sh_hflip_d;
    logic [7:0]        sh_col_q, sh_col_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              pix_vld_q, pix_vld_d;
    logic [PLANES-1:0] pix_dat_q, pix_dat_d;
    logic [7:0]        pix_col_q, pix_col_d;
    logic              underrun_q, underrun_d;

    logic              use_fb;
    logic [DW-1:0]     src_dat;
    logic              src_hflip;
    logic [7:0]        src_col;
    logic [IW-1:0]     src_idx;
    logic [IW-1:0]     k;
    logic              src_last;
    logic [PLANES-1:0] pix;

    // Pick the word to emit from (shifter, or fetch buffer when the shifter is empty) and gather pixel k across the planes.
    always_comb begin
        use_fb    = !sh_full_q;
        src_dat   = use_fb ? fb_dat_i   : sh_dat_q;
        src_hflip = use_fb ? fb_hflip_i : sh_hflip_q;
        src_col   = use_fb ? fb_col_i   : sh_col_q;
        src_idx   = use_fb ? '0         : idx_q;
        src_last  = (src_idx == IDX_LAST);
        k         = src_hflip ? (IDX_LAST - src_idx) : src_idx;
        pix       = '0;
        for (int i = 0; i < PPW; i++) begin
            if (k == IW'(i)) begin
                for (int p = 0; p < PLANES; p++) begin
                    pix[p] = src_dat[i + p * PPW];
                end
            end
        end
    end

    // The fetch buffer is consumed when the shifter is empty or emits its last pixel.
    assign drain_o = pix_en_i && fb_full_i && (!sh_full_q || (idx_q == IDX_LAST));

    // Pixel emission, index advance and shifter reload; outputs hold while PIX_EN is low.
    always_comb begin
        sh_dat_d   = sh_dat_q;
        sh_full_d  = sh_full_q;
        sh_hflip_d = sh_hflip_q;
        sh_col_d   = sh_col_q;
        idx_d      = idx_q;
        pix_vld_d  = pix_vld_q;
        pix_dat_d  = pix_dat_q;
        pix_col_d  = pix_col_q;
        underrun_d = 1'b0;
        if (pix_en_i) begin
            if (sh_full_q || fb_full_i) begin
                pix_vld_d = 1'b1;
                pix_dat_d = pix;
                pix_col_d = src_col;
                if (!src_last) begin
                    sh_dat_d   = src_dat;
                    sh_hflip_d = src_hflip;
                    sh_col_d   = src_col;
                    sh_full_d  = 1'b1;
                    idx_d      = src_idx + 1'b1;
                end else if (sh_full_q && fb_full_i) begin
                    // Last pixel out of the shifter: the waiting word moves in behind it with no gap.
                    sh_dat_d   = fb_dat_i;
                    sh_hflip_d = fb_hflip_i;
                    sh_col_d   = fb_col_i;
                    sh_full_d  = 1'b1;
                    idx_d      = '0;
                end else begin
                    sh_full_d = 1'b0;
                    idx_d     = '0;
                end
            end else begin
                pix_vld_d  = 1'b0;
                pix_dat_d  = '0;
                underrun_d = 1'b1;
            end
        end
    end

    // Shifter and pixel output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh_dat_q   <= '0;
            sh_full_q  <= 1'b0;
            sh_hflip_q <= 1'b0;
            sh_col_q   <= '0;
            idx_q      <= '0;
            pix_vld_q  <= 1'b0;
            pix_dat_q  <= '0;
            pix_col_q  <= '0;
            underrun_q <= 1'b0;
        end else begin
            sh_dat_q   <= sh_dat_d;
            sh_full_q  <= sh_full_d;
            sh_hflip_q <= sh_hflip_d;
            sh_col_q   <= sh_col_d;
            idx_q      <= idx_d;
            pix_vld_q  <= pix_vld_d;
            pix_dat_q  <= pix_dat_d;
            pix_col_q  <= pix_col_d;
            underrun_q <= underrun_d;
        end
    end

    assign pix_vld_o  = pix_vld_q;
    assign pix_dat_o  = pix_dat_q;
    assign pix_col_o  = pix_col_q;
    assign underrun_o = underrun_q;

endmodule

// File: rtl/gfx_rom_fetch.sv
// Tile ROM fetcher: one outstanding banked ROM access feeding a fetch buffer + planar pixel shifter.
// Latency: accept edge, ROM_LAT cycles of access, one release cycle; ROM_LAT+2 cycles per word.
// Backpressure: REQ_READY only in IDLE with the fetch buffer empty or draining this cycle.
module gfx_rom_fetch
    import gfx_rom_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int PLANES  = PLANES_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input logic      M24,
    input logic      RES,
    gfx_rom_if.slave bus
);
    localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ROM_LAT - 1);

    fetch_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-2:0] rom_addr_q, rom_addr_d;
    logic          rom_cen_q, rom_cen_d;
    logic          oe_lo_q, oe_lo_d;
    logic          oe_hi_q, oe_hi_d;
    logic          req_hflip_q, req_hflip_d;
    logic [7:0]    req_col_q, req_col_d;
    logic [DW-1:0] fb_dat_q, fb_dat_d;
    logic          fb_full_q, fb_full_d;
    logic          fb_hflip_q, fb_hflip_d;
    logic [7:0]    fb_col_q, fb_col_d;
    logic          run_q;
    logic          req_rdy;
    logic          accept;
    logic          capture;
    logic          drain;

    // run_q keeps REQ_READY low during reset and lets it rise on the first edge after release.
    assign req_rdy       = run_q && (state_q == IDLE) && (!fb_full_q || drain);
    assign accept        = bus.REQ_VALID && req_rdy;
    assign bus.REQ_READY = req_rdy;

    // Fetch FSM: ROM strobes go low on accept, are held for ROM_LAT cycles, and are released on
    // the same edge that samples ROM_DATA (entry into CAPTURE); CAPTURE is the bus release cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rom_addr_d  = rom_addr_q;
        rom_cen_d   = rom_cen_q;
        oe_lo_d     = oe_lo_q;
        oe_hi_d     = oe_hi_q;
        req_hflip_d = req_hflip_q;
        req_col_d   = req_col_q;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rom_addr_d  = bus.REQ_ADDR[AW-2:0];
                    rom_cen_d   = 1'b0;
                    oe_lo_d     = bus.REQ_ADDR[AW-1];
                    oe_hi_d     = !bus.REQ_ADDR[AW-1];
                    req_hflip_d = bus.REQ_HFLIP;
                    req_col_d   = bus.REQ_COL;
                    cnt_d       = '0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    capture   = 1'b1;
                    rom_cen_d = 1'b1;
                    oe_lo_d   = 1'b1;
                    oe_hi_d   = 1'b1;
                    state_d   = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fetch buffer: a capture may coincide with a drain, the shifter then takes the old word.
    always_comb begin
        fb_dat_d   = fb_dat_q;
        fb_full_d  = fb_full_q;
        fb_hflip_d = fb_hflip_q;
        fb_col_d   = fb_col_q;
        if (drain) begin
            fb_full_d = 1'b0;
        end
        if (capture) begin
            fb_dat_d   = bus.ROM_DATA;
            fb_full_d  = 1'b1;
            fb_hflip_d = req_hflip_q;
            fb_col_d   = req_col_q;
        end
    end

    // State, ROM strobe and fetch buffer registers; reset abandons any access in flight.
    always_ff @(posedge M24 or negedge RES) begin
        if (!RES) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rom_addr_q  <= '0;
            rom_cen_q   <= 1'b1;
            oe_lo_q     <= 1'b1;
            oe_hi_q     <= 1'b1;
            req_hflip_q <= 1'b0;
            req_col_q   <= '0;
            fb_dat_q    <= '0;
            fb_full_q   <= 1'b0;
            fb_hflip_q  <= 1'b0;
            fb_col_q    <= '0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rom_addr_q  <= rom_addr_d;
            rom_cen_q   <= rom_cen_d;
            oe_lo_q     <= oe_lo_d;
            oe_hi_q     <= oe_hi_d;
            req_hflip_q <= req_hflip_d;
            req_col_q   <= req_col_d;
            fb_dat_q    <= fb_dat_d;
            fb_full_q   <= fb_full_d;
            fb_hflip_q  <= fb_hflip_d;
            fb_col_q    <= fb_col_d;
            run_q       <= 1'b1;
        end
    end

    assign bus.ROM_ADDR    = rom_addr_q;
    assign bus.ROM_CEn     = rom_cen_q;
    assign bus.ROM_OE_LO_n = oe_lo_q;
    assign bus.ROM_OE_HI_n = oe_hi_q;

    gfx_planar_shifter #(
        .DW     (DW),
        .PLANES (PLANES)
    ) u_shifter (
        .clk_i      (M24),
        .rst_n_i    (RES),
        .pix_en_i   (bus.PIX_EN),
        .fb_full_i  (fb_full_q),
        .fb_dat_i   (fb_dat_q),
        .fb_hflip_i (fb_hflip_q),
        .fb_col_i   (fb_col_q),
        .drain_o    (drain),
        .pix_vld_o  (bus.PIX_VALID),
        .pix_dat_o  (bus.PIX_DATA),
        .pix_col_o  (bus.PIX_COL),
        .underrun_o (bus.UNDERRUN)
    );

endmodule

// File: tb/tb_gfx_rom_fetch.sv
// Bench for gfx_rom_fetch: ROM model, request driver and a pixel-sequence reference model.
// Latency: n/a.
// Backpressure: requests are held until the handshake completes.
module tb_gfx_rom_fetch;
    localparam int AW = 19, DW = 32, PLANES = 4, ROM_LAT = 8;
    localparam int PPW = DW / PLANES;

    typedef struct {
        logic [AW-1:0] addr;
        logic          hflip;
        logic [7:0]    col;
    } req_t;

    logic M24 = 1'b0;
    logic RES = 1'b0;
    always #5 M24 = ~M24;

    gfx_rom_if #(.AW(AW), .DW(DW), .PLANES(PLANES)) bus ();

    gfx_rom_fetch #(.AW(AW), .DW(DW), .PLANES(PLANES), .ROM_LAT(ROM_LAT)) dut (
        .M24 (M24),
        .RES (RES),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int en_mode  = 0;      // 0: PIX_EN off, 1: every cycle, 3: every third cycle
    int target   = 0;
    int ur_mid, ur_bad, hold_bad, oe_both;

    logic [31:0] rom_mem [logic [AW-1:0]];
    req_t        req_q [$];
    req_t        cur;
    logic [11:0] exp_q [$];
    logic [11:0] obs_q [$];
    logic        prev_vld;
    logic [3:0]  prev_dat;
    logic [7:0]  prev_col;

    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        if (rom_mem.exists(a)) return rom_mem[a];
        return ({13'd0, a} * 32'h9E37_79B1) ^ 32'hA5C3_0F96;
    endfunction

    task automatic clear_sb();
        obs_q.delete();
        exp_q.delete();
        ur_mid = 0; ur_bad = 0; hold_bad = 0; oe_both = 0;
    endtask

    // One clock: drive requests, model the ROM, record observations; outputs sampled #1 after the edge.
    task automatic tick();
        logic        pre_acc, pre_en, pre_res;
        logic [31:0] w;
        logic [3:0]  px;
        int          kk;
        #1;
        pre_acc = bus.REQ_VALID && bus.REQ_READY;
        pre_en  = bus.PIX_EN;
        pre_res = RES;
        @(posedge M24);
        #1;
        cyc++;
        if (pre_acc) begin
            w = rom_word(cur.addr);
            for (int i = 0; i < PPW; i++) begin
                kk = cur.hflip ? (PPW - 1 - i) : i;
                for (int p = 0; p < PLANES; p++) px[p] = w[kk + p * PPW];
                exp_q.push_back({cur.col, px});
            end
            bus.REQ_VALID = 1'b0;
        end
        if (!bus.REQ_VALID && req_q.size() > 0) begin
            cur = req_q.pop_front();
            bus.REQ_VALID = 1'b1;
            bus.REQ_ADDR  = cur.addr;
            bus.REQ_HFLIP = cur.hflip;
            bus.REQ_COL   = cur.col;
        end
        if (pre_en && pre_res && bus.PIX_VALID) obs_q.push_back({bus.PIX_COL, bus.PIX_DATA});
        if (bus.UNDERRUN) begin
            if (!pre_en || bus.PIX_VALID || bus.PIX_DATA != 4'h0) ur_bad++;
            if (obs_q.size() > 0 && obs_q.size() < target) ur_mid++;
        end
        if (!pre_en && pre_res && RES &&
            (bus.PIX_VALID !== prev_vld || bus.PIX_DATA !== prev_dat || bus.PIX_COL !== prev_col)) hold_bad++;
        prev_vld = bus.PIX_VALID; prev_dat = bus.PIX_DATA; prev_col = bus.PIX_COL;
        if (!bus.ROM_OE_LO_n && !bus.ROM_OE_HI_n) oe_both++;
        if (!bus.ROM_CEn && !bus.ROM_OE_LO_n)      bus.ROM_DATA = rom_word({1'b0, bus.ROM_ADDR});
        else if (!bus.ROM_CEn && !bus.ROM_OE_HI_n) bus.ROM_DATA = rom_word({1'b1, bus.ROM_ADDR});
        else                                        bus.ROM_DATA = 32'hDEAD_BEEF;
        bus.PIX_EN = (en_mode == 1) || (en_mode == 3 && (cyc % 3) == 0);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks += 9;
        if (bus.REQ_READY !== 1'b0)     begin n_err++; $display("FAIL reset_ready got %b want 0", bus.REQ_READY); end
        if (bus.ROM_ADDR !== '0)        begin n_err++; $display("FAIL reset_rom_addr got %h want 0", bus.ROM_ADDR); end
        if (bus.ROM_CEn !== 1'b1)       begin n_err++; $display("FAIL reset_cen got %b want 1", bus.ROM_CEn); end
        if (bus.ROM_OE_LO_n !== 1'b1)   begin n_err++; $display("FAIL reset_oe_lo got %b want 1", bus.ROM_OE_LO_n); end
        if (bus.ROM_OE_HI_n !== 1'b1)   begin n_err++; $display("FAIL reset_oe_hi got %b want 1", bus.ROM_OE_HI_n); end
        if (bus.PIX_VALID !== 1'b0)     begin n_err++; $display("FAIL reset_pix_valid got %b want 0", bus.PIX_VALID); end
        if (bus.PIX_DATA !== 4'h0)      begin n_err++; $display("FAIL reset_pix_data got %h want 0", bus.PIX_DATA); end
        if (bus.PIX_COL !== 8'h00)      begin n_err++; $display("FAIL reset_pix_col got %h want 0", bus.PIX_COL); end
        if (bus.UNDERRUN !== 1'b0)      begin n_err++; $display("FAIL reset_underrun got %b want 0", bus.UNDERRUN); end
        RES = 1'b1;
        tick();
        n_checks++;
        if (bus.REQ_READY !== 1'b1)     begin n_err++; $display("FAIL ready_after_release got %b want 1", bus.REQ_READY); end
    endtask

    // One access on the given bank; checks strobe timing, then the first-pixel latency and pixels.
    task automatic test_access(input string nm, input logic [AW-1:0] addr);
        int cen_low = 0, sel_low = 0, oth_low = 0, addr_bad = 0, rdy_bad = 0;
        logic hi;
        hi = addr[AW-1];
        clear_sb();
        en_mode = 0;
        req_q.push_back('{addr, 1'($urandom), 8'($urandom)});
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!bus.ROM_CEn) cen_low++;
            if (!(hi ? bus.ROM_OE_HI_n : bus.ROM_OE_LO_n)) sel_low++;
            if (!(hi ? bus.ROM_OE_LO_n : bus.ROM_OE_HI_n)) oth_low++;
            if (!bus.ROM_CEn && bus.ROM_ADDR !== addr[AW-2:0]) addr_bad++;
            if (!bus.ROM_CEn && bus.REQ_READY) rdy_bad++;
        end
        n_checks += 6;
        if (cen_low != ROM_LAT)       begin n_err++; $display("FAIL %s cen_low_cycles got %0d want %0d", nm, cen_low, ROM_LAT); end
        if (sel_low != ROM_LAT)       begin n_err++; $display("FAIL %s oe_sel_low_cycles got %0d want %0d", nm, sel_low, ROM_LAT); end
        if (oth_low != 0)             begin n_err++; $display("FAIL %s oe_other_low_cycles got %0d want 0", nm, oth_low); end
        if (addr_bad != 0)            begin n_err++; $display("FAIL %s rom_addr_bad_cycles got %0d want 0", nm, addr_bad); end
        if (rdy_bad != 0)             begin n_err++; $display("FAIL %s ready_during_access got %0d want 0", nm, rdy_bad); end
        if (bus.REQ_READY !== 1'b0)   begin n_err++; $display("FAIL %s ready_buffer_full got %b want 0", nm, bus.REQ_READY); end
        en_mode = 1;
        bus.PIX_EN = 1'b1;
        tick();
        n_checks++;
        if (obs_q.size() != 1)        begin n_err++; $display("FAIL %s first_pixel_count got %0d want 1", nm, obs_q.size()); end
        for (int i = 0; i < 20 && obs_q.size() < PPW; i++) tick();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL %s pixel_count got %0d want %0d", nm, obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL %s pixel[%0d] got %h want %h", nm, i, obs_q[i], exp_q[i]); end
        end
        en_mode = 0;
        tick();
    endtask

    task automatic test_pixel_patterns();
        logic [3:0] lit;
        int w, k;
        clear_sb();
        rom_mem[19'h00010] = 32'h0000_0001;
        rom_mem[19'h00012] = 32'hFF00_0000;
        rom_mem[19'h40013] = 32'h8080_8080;
        req_q.push_back('{19'h00010, 1'b0, 8'h3C});
        req_q.push_back('{19'h00010, 1'b1, 8'h5A});
        req_q.push_back('{19'h00012, 1'b0, 8'hC3});
        req_q.push_back('{19'h40013, 1'b0, 8'h81});
        target  = 4 * PPW;
        en_mode = 1;
        for (int i = 0; i < 400 && obs_q.size() < target; i++) tick();
        n_checks++;
        if (obs_q.size() != target) begin n_err++; $display("FAIL patterns_count got %0d want %0d", obs_q.size(), target); end
        for (int i = 0; i < obs_q.size() && i < target; i++) begin
            w = i / PPW; k = i % PPW;
            lit = (w == 0) ? ((k == 0) ? 4'h1 : 4'h0) :
                  (w == 1) ? ((k == PPW - 1) ? 4'h1 : 4'h0) :
                  (w == 2) ? 4'h8 : ((k == PPW - 1) ? 4'hF : 4'h0);
            n_checks += 2;
            if (obs_q[i][3:0] !== lit)  begin n_err++; $display("FAIL patterns_data[%0d] got %h want %h", i, obs_q[i][3:0], lit); end
            if (obs_q[i] !== exp_q[i])  begin n_err++; $display("FAIL patterns_model[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        en_mode = 0;
        tick();
    endtask

    task automatic test_back_to_back(input string nm, input int mode, input int nwords);
        clear_sb();
        for (int i = 0; i < nwords; i++) req_q.push_back('{19'($urandom), 1'($urandom), 8'($urandom)});
        target  = nwords * PPW;
        en_mode = mode;
        for (int i = 0; i < 2000 && obs_q.size() < target; i++) tick();
        n_checks += 3;
        if (obs_q.size() != target) begin n_err++; $display("FAIL %s pixel_count got %0d want %0d", nm, obs_q.size(), target); end
        if (ur_bad != 0)            begin n_err++; $display("FAIL %s underrun_with_pixel got %0d want 0", nm, ur_bad); end
        if (oe_both != 0)           begin n_err++; $display("FAIL %s both_oe_low got %0d want 0", nm, oe_both); end
        if (mode == 3) begin
            n_checks += 2;
            if (ur_mid != 0)        begin n_err++; $display("FAIL %s gapless_underruns got %0d want 0", nm, ur_mid); end
            if (hold_bad != 0)      begin n_err++; $display("FAIL %s hold_when_idle got %0d want 0", nm, hold_bad); end
        end else begin
            n_checks++;
            if (ur_mid == 0)        begin n_err++; $display("FAIL %s expected_underruns got %0d want >0", nm, ur_mid); end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL %s pixel[%0d] got %h want %h", nm, i, obs_q[i], exp_q[i]); end
        end
        en_mode = 0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_access();
        int waited = 0;
        clear_sb();
        rom_mem[19'h00055] = 32'hFFFF_FFFF;
        en_mode = 1;
        req_q.push_back('{19'h00055, 1'b0, 8'h77});
        while (bus.ROM_CEn && waited < 20) begin tick(); waited++; end
        n_checks++;
        if (bus.ROM_CEn !== 1'b0) begin n_err++; $display("FAIL rst_mid access_start got cen=%b want 0", bus.ROM_CEn); end
        repeat (3) tick();
        RES = 1'b0;
        #1;
        n_checks += 3;
        if (bus.ROM_CEn !== 1'b1)     begin n_err++; $display("FAIL rst_mid cen got %b want 1", bus.ROM_CEn); end
        if (bus.ROM_OE_LO_n !== 1'b1) begin n_err++; $display("FAIL rst_mid oe_lo got %b want 1", bus.ROM_OE_LO_n); end
        if (bus.ROM_OE_HI_n !== 1'b1) begin n_err++; $display("FAIL rst_mid oe_hi got %b want 1", bus.ROM_OE_HI_n); end
        repeat (2) tick();
        RES = 1'b1;
        tick();
        n_checks++;
        if (bus.REQ_READY !== 1'b1)   begin n_err++; $display("FAIL rst_mid ready_after_release got %b want 1", bus.REQ_READY); end
        obs_q.delete();
        repeat (30) tick();
        n_checks++;
        if (obs_q.size() != 0)        begin n_err++; $display("FAIL rst_mid stale_pixels got %0d want 0", obs_q.size()); end
        en_mode = 0;
    endtask

    initial begin
        bus.REQ_VALID = 1'b0;
        bus.REQ_ADDR  = '0;
        bus.REQ_HFLIP = 1'b0;
        bus.REQ_COL   = '0;
        bus.ROM_DATA  = 32'hDEAD_BEEF;
        bus.PIX_EN    = 1'b0;
        prev_vld = 1'b0; prev_dat = '0; prev_col = '0;
        clear_sb();
        test_reset();
        test_access("access_lo", 19'h00003);
        test_access("access_hi", 19'h4001C);
        test_pixel_patterns();
        test_back_to_back("b2b_slow", 3, 6);
        test_back_to_back("b2b_fast", 1, 4);
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/gfx_rom_fetch.md
GFX_ROM_FETCH -- requirements
Module: gfx_rom_fetch

Interface
REQ-001 SHALL have parameter AW, default 19: tile ROM word-address width; the top bit selects the bank.
REQ-002 SHALL have parameter DW, default 32: ROM data width in bits.
REQ-003 SHALL have parameter PLANES, default 4: bitplanes per pixel; PPW = DW/PLANES pixels per word, with DW divisible by PLANES.
REQ-004 SHALL have parameter ROM_LAT, default 8: ROM access time in M24 cycles, at least 1.
REQ-005 SHALL have port M24, input, 1 bit: the single clock, all state rising-edge.
REQ-006 SHALL have port RES, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port REQ_VALID, input, 1 bit: a fetch request is present.
REQ-008 SHALL have port REQ_READY, output, 1 bit: a request is accepted on an edge where both REQ_VALID and REQ_READY are high.
REQ-009 SHALL have port REQ_ADDR, input, AW bits: ROM word address.
REQ-010 SHALL have port REQ_HFLIP, input, 1 bit: emit the pixels of the word in reversed order.
REQ-011 SHALL have port REQ_COL, input, 8 bits: colour attribute that travels with the word.
REQ-012 SHALL have port ROM_ADDR, output, AW-1 bits: address to both ROM banks.
REQ-013 SHALL have port ROM_CEn, output, 1 bit: ROM chip enable, active-low.
REQ-014 SHALL have ports ROM_OE_LO_n and ROM_OE_HI_n, output, 1 bit each: lower- and upper-bank output enables, active-low.
REQ-015 SHALL have port ROM_DATA, input, DW bits: data from the ROMs.
REQ-016 SHALL have port PIX_EN, input, 1 bit: pixel-clock enable.
REQ-017 SHALL have ports PIX_VALID (1 bit), PIX_DATA (PLANES bits) and PIX_COL (8 bits), outputs: registered pixel output.
REQ-018 SHALL have port UNDERRUN, output, 1 bit: single-cycle pulse when a pixel is requested but none is available.

Function
REQ-019 Fetch FSM SHALL have states IDLE, ACCESS and CAPTURE.
REQ-020 REQ_READY SHALL be high only when the FSM is in IDLE and the fetch buffer is empty, or is being drained in that same cycle.
REQ-021 On accept, SHALL register ROM_ADDR = REQ_ADDR[AW-2:0] and ROM_CEn = 0, assert ROM_OE_LO_n = 0 when REQ_ADDR[AW-1] = 0 or ROM_OE_HI_n = 0 when it is 1, latch REQ_HFLIP and REQ_COL, and go to ACCESS.
REQ-022 ACCESS SHALL hold all ROM outputs stable for exactly ROM_LAT cycles, then go to CAPTURE.
REQ-023 CAPTURE SHALL latch ROM_DATA into the fetch buffer and set its full flag.
REQ-024 CAPTURE SHALL drive ROM_CEn, ROM_OE_LO_n and ROM_OE_HI_n to 1 and go to IDLE.
REQ-025 The two output enables SHALL never be low at the same time.
REQ-026 The shifter SHALL be a second word buffer with a pixel index of width clog2(PPW), forming a double buffer with the fetch buffer.
REQ-027 Pixel k of a word SHALL be {D[k+(PLANES-1)*PPW], ..., D[k+PPW], D[k]}.
REQ-028 Emission order SHALL be k = 0..PPW-1, or PPW-1..0 when the latched hflip bit is set.
REQ-029 On a PIX_EN cycle with the shifter holding pixels, SHALL output the next pixel with PIX_VALID = 1 and PIX_COL = the latched colour, then advance the index.
REQ-030 On a PIX_EN cycle in which the last pixel is emitted, or in which the shifter is empty, SHALL move the fetch buffer (if full) into the shifter and clear the fetch buffer's full flag.
REQ-031 A fetch buffer loaded while the shifter is empty SHALL give its first pixel on the next PIX_EN.
REQ-032 A CAPTURE that coincides with a drain of the fetch buffer SHALL be legal: the shifter takes the old word and the fetch buffer takes the new word.
REQ-033 On a PIX_EN cycle with both the shifter and the fetch buffer empty, SHALL output PIX_VALID = 0 and PIX_DATA = 0 and pulse UNDERRUN high for one cycle.
REQ-034 Outputs SHALL hold their values on cycles where PIX_EN = 0; UNDERRUN SHALL be 0 on those cycles.
REQ-035 Throughput SHALL allow gapless output when ROM_LAT + 2 <= PPW divided by the PIX_EN rate.

Reset
REQ-036 RES low SHALL asynchronously clear: FSM to IDLE, both full flags to 0, pixel index to 0, ROM_ADDR to 0, ROM_CEn, ROM_OE_LO_n and ROM_OE_HI_n to 1, REQ_READY to 0, PIX_VALID, PIX_DATA, PIX_COL and UNDERRUN to 0.
REQ-037 Reset during ACCESS SHALL abandon the access and discard its data.
REQ-038 REQ_READY SHALL rise on the first edge after RES returns high.

Structure
REQ-039 A shared package gfx_rom_pkg SHALL hold the FSM state enum, the default parameter values, and a function to compute PPW and the index width.
REQ-040 The design SHALL have one sub-module, gfx_planar_shifter, containing the shifter, the plane-to-pixel mux and the hflip order.

Verification
REQ-041 Request REQ_ADDR = 0x00003 with ROM_LAT = 8 -> ROM_CEn = 0 and ROM_OE_LO_n = 0 for exactly 8 cycles with ROM_ADDR = 0x00003, ROM_OE_HI_n held at 1, and REQ_READY low throughout.
REQ-042 Request REQ_ADDR = 0x4001C -> ROM_ADDR = 0x0001C and ROM_OE_HI_n = 0, with ROM_OE_LO_n held at 1.
REQ-043 ROM_DATA = 0x00000001, hflip = 0, PIX_EN always high -> PIX_DATA sequence 1,0,0,0,0,0,0,0; the same word with hflip = 1 -> 0,0,0,0,0,0,0,1.
REQ-044 ROM_DATA = 0xFF000000 -> eight pixels of 4'h8; ROM_DATA = 0x80808080 -> pixel 7 = 4'hF and the others 0; PIX_COL equals REQ_COL throughout.
REQ-045 Back-to-back requests with PIX_EN every 3rd cycle -> no UNDERRUN after the first word; with PIX_EN every cycle -> UNDERRUN pulses with PIX_VALID = 0.
REQ-046 RES asserted in the 4th ACCESS cycle -> the ROM outputs return to 1 immediately, no pixel from that word is ever emitted, and REQ_READY = 1 one edge after release.
